// File: rtl/qspim_pkg.sv
// Shared types and constants for the Wishbone to quad-SPI master bridge.
package qspim_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        SETUP = 4'd1,
        CMD   = 4'd2,
        ADDR  = 4'd3,
        DUMMY = 4'd4,
        WDATA = 4'd5,
        RDATA = 4'd6,
        HOLD  = 4'd7,
        ACK   = 4'd8,
        GAP   = 4'd9
    } state_e;

    localparam logic [3:0] CMD_WR = 4'h2;
    localparam logic [3:0] CMD_RD = 4'h3;

    localparam logic [3:0] NIB_CMD  = 4'd2;
    localparam logic [3:0] NIB_ADDR = 4'd6;
    localparam logic [3:0] NIB_DATA = 4'd8;

    function automatic logic [7:0] cmd_byte(input logic we, input logic [3:0] sel);
        return {(we ? CMD_WR : CMD_RD), sel};
    endfunction

endpackage

// File: rtl/qspim_wb_clkgen.sv
// Half-period counter for sclk; tick marks every half-period while enabled,
// rise/fall flag the sys_clk edge on which sclk changes.
module qspim_clkgen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sclk_en,
    output logic sclk,
    output logic tick,
    output logic rise,
    output logic fall
);
    localparam logic [7:0] RELOAD = 8'(CLK_DIV);

    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;

    always_comb begin
        tick   = en && (cnt_q == '0);
        rise   = tick && sclk_en && !sclk_q;
        fall   = tick && sclk_en && sclk_q;
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en) begin
            cnt_d  = RELOAD;
            sclk_d = 1'b0;
        end else if (tick) begin
            cnt_d = RELOAD;
            if (sclk_en) begin
                sclk_d = !sclk_q;
            end
        end else begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= RELOAD;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/qspim_wb.sv
// Wishbone slave to quad-SPI master bridge: one 32-bit WB access becomes one
// QSPI frame (cmd, 24-bit address, then write data or dummy + read data).
module qspim_wb
    import qspim_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned DUMMY_CYC = 4,
    parameter int unsigned CS_GAP    = 2
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [31:0] wbs_adr_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        sclk,
    output logic        ssn,
    output logic [3:0]  sdout,
    output logic        sdout_oen,
    input  logic [3:0]  sdin,
    output logic        busy,
    output logic [3:0]  st
);
    // ACK and the IDLE acceptance cycle already keep ssn high, GAP pads the rest
    localparam int unsigned GAP_LEN   = (CS_GAP > 2) ? CS_GAP - 2 : 0;
    localparam logic [7:0]  GAP_LOAD  = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;
    localparam logic [3:0]  DUMMY_LOAD = 4'(DUMMY_CYC);

    state_e      state_q, state_d;
    logic [3:0]  nib_q, nib_d;
    logic [7:0]  gap_q, gap_d;
    logic [59:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic        we_q, we_d;
    logic        ssn_q, ssn_d;
    logic        oen_q, oen_d;
    logic [3:0]  sdout_q, sdout_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic        busy_q, busy_d;
    logic [7:0]  cmd;
    logic        clk_en, sclk_en, tick, rise, fall;

    qspim_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .en      (clk_en),
        .sclk_en (sclk_en),
        .sclk    (sclk),
        .tick    (tick),
        .rise    (rise),
        .fall    (fall)
    );

    always_comb begin
        cmd     = cmd_byte(wbs_we_i, wbs_sel_i);
        state_d = state_q;
        nib_d   = nib_q;
        gap_d   = gap_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        we_d    = we_q;
        ssn_d   = ssn_q;
        oen_d   = oen_q;
        sdout_d = sdout_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        clk_en  = 1'b0;
        sclk_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i && !ack_q && !err_q) begin
                    if (wbs_adr_i[31:24] != '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                        we_d    = wbs_we_i;
                        tx_d    = {cmd[3:0], wbs_adr_i[23:0], wbs_dat_i};
                        sdout_d = cmd[7:4];
                        ssn_d   = 1'b0;
                        oen_d   = 1'b0;
                        nib_d   = NIB_CMD;
                    end
                end
            end
            SETUP: begin
                clk_en = 1'b1;
                if (tick) begin
                    state_d = CMD;
                end
            end
            CMD, ADDR, WDATA: begin
                clk_en  = 1'b1;
                sclk_en = 1'b1;
                if (fall) begin
                    tx_d    = {tx_q[55:0], 4'h0};
                    sdout_d = tx_q[59:56];
                    if (nib_q == 4'd1) begin
                        if (state_q == CMD) begin
                            state_d = ADDR;
                            nib_d   = NIB_ADDR;
                        end else if (state_q == WDATA) begin
                            state_d = HOLD;
                            sdout_d = '0;
                        end else if (we_q) begin
                            state_d = WDATA;
                            nib_d   = NIB_DATA;
                        end else begin
                            state_d = (DUMMY_LOAD == '0) ? RDATA : DUMMY;
                            nib_d   = (DUMMY_LOAD == '0) ? NIB_DATA : DUMMY_LOAD;
                            oen_d   = 1'b1;
                            sdout_d = '0;
                        end
                    end else begin
                        nib_d = nib_q - 4'd1;
                    end
                end
            end
            DUMMY, RDATA: begin
                clk_en  = 1'b1;
                sclk_en = 1'b1;
                if (rise && state_q == RDATA) begin
                    rx_d = {rx_q[27:0], sdin};
                end
                if (fall) begin
                    if (nib_q == 4'd1) begin
                        state_d = (state_q == DUMMY) ? RDATA : HOLD;
                        nib_d   = NIB_DATA;
                    end else begin
                        nib_d = nib_q - 4'd1;
                    end
                end
            end
            HOLD: begin
                clk_en = 1'b1;
                if (tick) begin
                    state_d = ACK;
                    ssn_d   = 1'b1;
                    oen_d   = 1'b1;
                    sdout_d = '0;
                    // A master that dropped cyc gets neither ack nor new read data
                    ack_d   = wbs_cyc_i;
                    if (wbs_cyc_i && !we_q) begin
                        dat_d = rx_q;
                    end
                end
            end
            ACK: begin
                state_d = (GAP_LEN == 0) ? IDLE : GAP;
                gap_d   = GAP_LOAD;
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nib_q   <= '0;
            gap_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            we_q    <= 1'b0;
            ssn_q   <= 1'b1;
            oen_q   <= 1'b1;
            sdout_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            we_q    <= we_d;
            ssn_q   <= ssn_d;
            oen_q   <= oen_d;
            sdout_q <= sdout_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
        end
    end

    assign wbs_dat_o = dat_q;
    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign ssn       = ssn_q;
    assign sdout     = sdout_q;
    assign sdout_oen = oen_q;
    assign busy      = busy_q;
    assign st        = state_q;

endmodule

// File: tb/tb_qspim_wb.sv
// Self-checking bench for qspim_wb: vector table plus random accesses against a
// frame-level model, and hand sequences for back-to-back, cyc drop and reset.
module tb_qspim_wb;
    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned DUMMY_CYC = 4;
    localparam int unsigned CS_GAP    = 3;
    localparam int unsigned H         = CLK_DIV + 1;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o, sclk, ssn, sdout_oen, busy;
    logic [3:0]  sdout, st;
    logic [3:0]  sdin = '0;

    always #5 sys_clk = ~sys_clk;

    qspim_wb #(.CLK_DIV(CLK_DIV), .DUMMY_CYC(DUMMY_CYC), .CS_GAP(CS_GAP)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_adr_i(wbs_adr_i),
        .wbs_we_i(wbs_we_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .sclk(sclk), .ssn(ssn), .sdout(sdout), .sdout_oen(sdout_oen),
        .sdin(sdin), .busy(busy), .st(st)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdata;
        logic [7:0]  exp_cmd;
        logic        exp_err;
    } vec_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_dat_o = '0;
    logic [31:0] rd_word = '0;

    // Bus monitor and QSPI slave model, sampling on the falling sys_clk edge
    logic        prev_sclk = 1'b0, prev_ssn = 1'b1;
    int unsigned rise_cnt = 0, low_cycles = 0, high_cycles = 0, last_gap = 0;
    int unsigned frames = 0, acks = 0, errs = 0;
    logic [3:0]  mon_nib [0:31];
    logic        mon_oen [0:31];

    always @(negedge sys_clk) begin
        int unsigned k;
        if (prev_ssn && !ssn) begin
            frames++;
            rise_cnt   = 0;
            low_cycles = 0;
            last_gap   = high_cycles;
        end
        if (!prev_ssn && ssn) high_cycles = 0;
        if (ssn) high_cycles++;
        else low_cycles++;
        if (!prev_sclk && sclk) begin
            if (rise_cnt < 32) begin
                mon_nib[rise_cnt] = sdout;
                mon_oen[rise_cnt] = sdout_oen;
            end
            rise_cnt++;
        end
        if (rise_cnt >= 8 + DUMMY_CYC && rise_cnt < 16 + DUMMY_CYC) begin
            k = rise_cnt - (8 + DUMMY_CYC);
            sdin = rd_word[31 - 4*k -: 4];
        end else begin
            sdin = 4'($urandom);
        end
        if (wbs_ack_o) acks++;
        if (wbs_err_o) errs++;
        prev_sclk = sclk;
        prev_ssn  = ssn;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_frame(input vec_t v, input string tag);
        logic [31:0] hdr_got, dat_got;
        int unsigned n, bad;
        n = v.we ? 16 : 16 + DUMMY_CYC;
        hdr_got = '0;
        dat_got = '0;
        bad = 0;
        for (int unsigned i = 0; i < 8; i++) hdr_got = {hdr_got[27:0], mon_nib[i]};
        for (int unsigned i = 8; i < 16; i++) dat_got = {dat_got[27:0], mon_nib[i]};
        for (int unsigned i = 0; i < n; i++)
            if (mon_oen[i] !== ((!v.we && i >= 8) ? 1'b1 : 1'b0)) bad++;
        chk({tag, " rises"}, rise_cnt, n);
        chk({tag, " cmd_adr"}, hdr_got, {v.exp_cmd, v.adr[23:0]});
        if (v.we) chk({tag, " wdata"}, dat_got, v.dat);
        chk({tag, " oen"}, bad, 0);
        chk({tag, " ssn_low"}, low_cycles, (2*n + 2) * H);
    endtask

    task automatic wait_resp(output bit done);
        int unsigned n;
        done = 0;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge sys_clk);
            n++;
            if (wbs_ack_o || wbs_err_o) done = 1;
            else if (busy) begin
                wbs_adr_i = $urandom;
                wbs_dat_i = $urandom;
                wbs_sel_i = 4'($urandom);
                wbs_we_i  = 1'($urandom);
            end
        end
    endtask

    task automatic drive(input vec_t v);
        rd_word   = v.rdata;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = v.we;
        wbs_adr_i = v.adr;
        wbs_dat_i = v.dat;
        wbs_sel_i = v.sel;
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int unsigned a0, e0, f0;
        bit done;
        @(negedge sys_clk);
        a0 = acks; e0 = errs; f0 = frames;
        drive(v);
        wait_resp(done);
        chk({tag, " responded"}, done, 1);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk({tag, " acks"}, acks - a0, v.exp_err ? 0 : 1);
        chk({tag, " errs"}, errs - e0, v.exp_err ? 1 : 0);
        chk({tag, " frames"}, frames - f0, v.exp_err ? 0 : 1);
        if (!v.exp_err) begin
            check_frame(v, tag);
            if (!v.we) exp_dat_o = v.rdata;
        end
        chk({tag, " dat_o"}, wbs_dat_o, exp_dat_o);
        chk({tag, " idle"}, {ssn, busy, sclk}, 3'b100);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.rdata = rdata;
        v.exp_cmd = {(we ? 4'h2 : 4'h3), sel};
        v.exp_err = (adr[31:24] != 8'h00);
        return v;
    endfunction

    initial begin
        vec_t tbl [6];
        vec_t v, v2;
        bit   done;
        int unsigned a0, f0, n;

        tbl[0] = '{1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'hF, 32'h0, 8'h2F, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_0040, 32'h0,         4'hF, 32'h1234_5678, 8'h3F, 1'b0};
        tbl[2] = '{1'b1, 32'h00AB_CDEF, 32'h0BAD_F00D, 4'h3, 32'h0, 8'h23, 1'b0};
        tbl[3] = '{1'b0, 32'h00FF_FFFC, 32'h5555_AAAA, 4'h1, 32'hCAFE_0001, 8'h31, 1'b0};
        tbl[4] = '{1'b1, 32'h0100_0000, 32'h1111_2222, 4'hF, 32'h0, 8'h2F, 1'b1};
        tbl[5] = '{1'b0, 32'hFF00_0010, 32'h0,         4'hF, 32'h9999_9999, 8'h3F, 1'b1};

        repeat (2) @(negedge sys_clk);
        chk("reset io", {sclk, ssn, sdout, sdout_oen}, 7'b0_1_0000_1);
        chk("reset wb", {wbs_ack_o, wbs_err_o, busy}, 3'b000);
        chk("reset dat_o", wbs_dat_o, 32'h0);
        chk("reset st", st, 4'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int unsigned i = 0; i < 6; i++) do_txn(tbl[i], $sformatf("tbl%0d", i));

        for (int unsigned i = 0; i < 10; i++) begin
            v = mk(1'($urandom), {(($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00),
                   24'($urandom)}, $urandom, 4'($urandom), $urandom);
            do_txn(v, $sformatf("rnd%0d", i));
        end

        // Back-to-back writes with stb held across the ack
        v  = mk(1'b1, 32'h0000_0100, 32'hA5A5_0F0F, 4'hF, 32'h0);
        v2 = mk(1'b1, 32'h0012_3456, 32'h7654_3210, 4'h6, 32'h0);
        @(negedge sys_clk);
        a0 = acks; f0 = frames;
        drive(v);
        wait_resp(done);
        chk("b2b first ack", {done, wbs_ack_o}, 2'b11);
        drive(v2);
        @(negedge sys_clk);
        wait_resp(done);
        chk("b2b second ack", {done, wbs_ack_o}, 2'b11);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("b2b acks", acks - a0, 2);
        chk("b2b frames", frames - f0, 2);
        chk("b2b ssn gap", last_gap, CS_GAP);
        check_frame(v2, "b2b frame2");

        // Master drops cyc mid-frame: frame still completes, ack suppressed
        v = mk(1'b0, 32'h0000_0800, 32'h0, 4'hF, 32'h3C3C_C3C3);
        @(negedge sys_clk);
        a0 = acks; f0 = frames;
        drive(v);
        n = 0;
        while (!(busy && rise_cnt == 3 && !ssn) && n < 2000) begin @(negedge sys_clk); n++; end
        chk("drop reached", n < 2000, 1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        n = 0;
        while (busy && n < 2000) begin @(negedge sys_clk); n++; end
        repeat (2) @(negedge sys_clk);
        chk("drop acks", acks - a0, 0);
        chk("drop frames", frames - f0, 1);
        chk("drop rises", rise_cnt, 16 + DUMMY_CYC);
        chk("drop dat_o", wbs_dat_o, exp_dat_o);

        // Reset in the middle of the address phase
        v = mk(1'b1, 32'h00C0_FFEE, 32'h1357_9BDF, 4'hF, 32'h0);
        @(negedge sys_clk);
        drive(v);
        n = 0;
        while (!(rise_cnt == 4 && !ssn) && n < 2000) begin @(negedge sys_clk); n++; end
        chk("rst reached addr", n < 2000, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst mid io", {sclk, ssn, sdout, sdout_oen}, 7'b0_1_0000_1);
        chk("rst mid wb", {wbs_ack_o, busy, st}, 6'b0_0_0000);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        exp_dat_o = '0;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        do_txn(v, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspim_wb.md
Name: qspim_wb

Overview:
- Wishbone-slave to quad-SPI master bridge.
- Turns each single 32-bit WB access into one QSPI frame: command, 24-bit address, then write data, or dummy cycles followed by read data.
- It is the host end of the qspis_* link, used by the bring-up FPGA to drive the target's QSPI slave / WB-master port.

Parameters:
- CLK_DIV, 2, half-period of sclk in sys_clk cycles minus 1 (sclk = sys_clk/(2*(CLK_DIV+1))); legal range 0..255.
- DUMMY_CYC, 4, sclk cycles between address and read data (target turnaround / WB read latency).
- CS_GAP, 2, sys_clk cycles ssn stays high between frames.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  WB cycle
- wbs_stb_i  in  1  WB strobe
- wbs_adr_i  in  32  byte address; only [23:0] are sent
- wbs_we_i  in  1  write
- wbs_dat_i  in  32  write data
- wbs_sel_i  in  4  byte enables
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  one-cycle acknowledge
- wbs_err_o  out  1  one-cycle error
- sclk  out  1  QSPI clock, mode 0 (idle low)
- ssn  out  1  chip select, active low
- sdout  out  4  quad data out
- sdout_oen  out  1  output enable, active low (0 = drive)
- sdin  in  4  quad data in
- busy  out  1  frame in progress (debug)
- st  out  4  FSM state (debug)

Behaviour:
- Reset values:
  - sclk=0, ssn=1, sdout=0, sdout_oen=1.
  - wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, busy=0, st=IDLE.
- Frame format: all phases quad, MSB nibble first.
  - cmd[7:0] = {4'h2 write | 4'h3 read, wbs_sel_i}.
  - Then adr[23:0].
  - Write: then dat[31:0].
  - Read: then DUMMY_CYC sclk, then 32 read bits.
- Edges:
  - sdout updates only while sclk is low, at least one half-period before the rising edge.
  - sdin is sampled on the sys_clk where sclk rises.
- Request acceptance:
  - A request is accepted in IDLE when cyc&stb&!ack&!err.
  - adr, we, dat and sel are captured into shadow registers; the WB inputs are ignored afterwards.
  - wbs_adr_i[31:24]!=0: wbs_err_o=1 for one cycle, no frame is issued, return to IDLE.
- FSM:
  - IDLE -> SETUP: ssn=0, sdout_oen=0, first cmd nibble placed; wait one half-period.
  - SETUP -> CMD: 2 sclk.
  - CMD -> ADDR: 6 sclk.
  - ADDR -> WDATA (8 sclk) when write, or DUMMY when read.
  - DUMMY: sdout_oen=1 from the falling edge ending ADDR; DUMMY_CYC sclk. DUMMY_CYC=0 skips directly to RDATA.
  - RDATA: 8 sclk; the shift register takes {sh[27:0],sdin} on each rising edge.
  - WDATA/RDATA -> HOLD: sclk low, one half-period, then ssn=1, sdout_oen=1.
  - HOLD -> ACK: wbs_ack_o=1 for exactly one cycle; wbs_dat_o loaded with the read word (unchanged on write).
  - ACK -> GAP: CS_GAP cycles with ssn high.
  - GAP -> IDLE.
- Counters:
  - Half-period counter reloads CLK_DIV; sclk toggles at terminal count.
  - Nibble counter is 4 bits, counting down per phase.
- Latency: write frame = 16 sclk + setup/hold; read frame = 16+DUMMY_CYC sclk.
- WB master dropping cyc mid-frame:
  - The frame completes.
  - ack is suppressed if cyc is low in ACK.
  - No new request until IDLE.
- busy=1 from SETUP through GAP.
- Reset asserted mid-frame: all outputs return to reset values asynchronously; ssn rises immediately.

Decomposition:
- Package qspim_pkg:
  - State encoding: IDLE, SETUP, CMD, ADDR, DUMMY, WDATA, RDATA, HOLD, ACK, GAP.
  - CMD_WR=4'h2, CMD_RD=4'h3.
  - Phase nibble counts: 2, 6, 8.
- Sub-module qspim_clkgen: half-period counter producing sclk plus one-cycle rise/fall strobes; enabled by the FSM.

Test Plan:
- Write adr=0x0000_1234, dat=0xDEADBEEF, sel=F, CLK_DIV=2 -> nibbles 2,F,0,0,1,2,3,4,D,E,A,D,B,E,E,F on sdout at rising edges. ssn low for exactly 16 sclk + setup/hold. One ack.
- Read adr=0x00_0040 with sdin model returning 0x1234_5678 after 4 dummy sclk -> cmd nibbles 3,F. sdout_oen=1 from DUMMY start. wbs_dat_o=0x12345678 with ack.
- sel=4'b0011 write -> cmd byte 0x23. Read with sel=4'h1 -> cmd byte 0x31.
- wbs_adr_i=0x0100_0000 -> err pulse one cycle. ssn never falls. No ack.
- Back-to-back writes with stb held -> exactly CS_GAP cycles of ssn high between frames, two acks total.
- rst_n low mid-ADDR -> ssn=1, sclk=0, sdout_oen=1 in the same cycle. The next request after reset produces a clean full frame.
